// File: rtl/controlador_sequenciador.sv
// SAP-1 control/sequencer: six-state one-hot ring (T1..T6) decoding bus/load controls from the opcode.
// Optional macro SAP1_SKIP_NOP_EN returns to T1 early when the remaining T-states would do nothing.
module controlador_sequenciador #(
   parameter logic [3:0] OPC_LDA = 4'b0000,
   parameter logic [3:0] OPC_ADD = 4'b0001,
   parameter logic [3:0] OPC_SUB = 4'b0010,
   parameter logic [3:0] OPC_OUT = 4'b1110,
   parameter logic [3:0] OPC_HLT = 4'b1111
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       habilita,
   input  logic [3:0] opcode,
   output logic [5:0] t,
   output logic       cp,
   output logic       ep,
   output logic       lm,
   output logic       ce,
   output logic       li,
   output logic       ei,
   output logic       la,
   output logic       ea,
   output logic       su,
   output logic       eu,
   output logic       lb,
   output logic       lo,
   output logic       hlt
);

   typedef enum logic [5:0] {
      T1 = 6'b000001,
      T2 = 6'b000010,
      T3 = 6'b000100,
      T4 = 6'b001000,
      T5 = 6'b010000,
      T6 = 6'b100000
   } state_t;

   state_t state, state_nxt;
   logic   halted, halted_nxt;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state  <= T1;
         halted <= 1'b0;
      end else begin
         state  <= state_nxt;
         halted <= halted_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      halted_nxt = halted;
      t   = state;
      hlt = halted;
      cp = 1'b0; ep = 1'b0; lm = 1'b0; ce = 1'b0; li = 1'b0; ei = 1'b0;
      la = 1'b0; ea = 1'b0; su = 1'b0; eu = 1'b0; lb = 1'b0; lo = 1'b0;

      if (habilita && !halted) begin
         case (state)
            T1: state_nxt = T2;
            T2: state_nxt = T3;
            T3: state_nxt = T4;
            T4: begin
               // HLT parks the ring in T4; only clr releases it
               if (opcode == OPC_HLT) halted_nxt = 1'b1;
`ifdef SAP1_SKIP_NOP_EN
               else if (!(opcode inside {OPC_LDA, OPC_ADD, OPC_SUB})) state_nxt = T1;
`endif
               else state_nxt = T5;
            end
            T5: begin
`ifdef SAP1_SKIP_NOP_EN
               if (opcode == OPC_LDA) state_nxt = T1;
               else state_nxt = T6;
`else
               state_nxt = T6;
`endif
            end
            T6:      state_nxt = T1;
            default: state_nxt = T1;
         endcase
      end

      if (!halted) begin
         case (state)
            T1: begin ep = 1'b1; lm = 1'b1; end
            T2: cp = 1'b1;
            T3: begin ce = 1'b1; li = 1'b1; end
            T4: begin
               if (opcode inside {OPC_LDA, OPC_ADD, OPC_SUB}) begin
                  ei = 1'b1; lm = 1'b1;
               end else if (opcode == OPC_OUT) begin
                  ea = 1'b1; lo = 1'b1;
               end
            end
            T5: begin
               if (opcode == OPC_LDA) begin
                  ce = 1'b1; la = 1'b1;
               end else if (opcode inside {OPC_ADD, OPC_SUB}) begin
                  ce = 1'b1; lb = 1'b1;
               end
            end
            T6: begin
               if (opcode inside {OPC_ADD, OPC_SUB}) begin
                  eu = 1'b1; la = 1'b1;
                  su = (opcode == OPC_SUB);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_controlador_sequenciador.sv
// Directed table-driven bench for controlador_sequenciador plus hand sequences for async clear and HLT.
module tb_controlador_sequenciador;

   logic       clk = 1'b0;
   logic       clr, habilita;
   logic [3:0] opcode;
   logic [5:0] t;
   logic cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt;

   int checks = 0;
   int errors = 0;

   // control vector bit order: {cp,ep,lm,ce,li,ei,la,ea,su,eu,lb,lo,hlt}
   localparam logic [12:0] N_ = 13'h0000;
   localparam logic [12:0] CP = 13'h1000, EP = 13'h0800, LM = 13'h0400, CE = 13'h0200;
   localparam logic [12:0] LI = 13'h0100, EI = 13'h0080, LA = 13'h0040, EA = 13'h0020;
   localparam logic [12:0] SU = 13'h0010, EU = 13'h0008, LB = 13'h0004, LO = 13'h0002;
   localparam logic [12:0] HL = 13'h0001;

   localparam logic [5:0] S1 = 6'b000001, S2 = 6'b000010, S3 = 6'b000100;
   localparam logic [5:0] S4 = 6'b001000, S5 = 6'b010000, S6 = 6'b100000;

   typedef struct {
      logic       clr;
      logic       hab;
      logic [3:0] op;
      logic [5:0] t;
      logic [12:0] ctl;
   } vec_t;

   vec_t vecs[$];

   controlador_sequenciador dut (
      .clk(clk), .clr(clr), .habilita(habilita), .opcode(opcode), .t(t),
      .cp(cp), .ep(ep), .lm(lm), .ce(ce), .li(li), .ei(ei), .la(la), .ea(ea),
      .su(su), .eu(eu), .lb(lb), .lo(lo), .hlt(hlt)
   );

   always #5 clk = ~clk;

   task automatic add(input logic c, input logic h, input logic [3:0] o,
                      input logic [5:0] et, input logic [12:0] ec);
      vec_t v;
      v.clr = c; v.hab = h; v.op = o; v.t = et; v.ctl = ec;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [5:0] et, input logic [12:0] ec);
      logic [12:0] ctl;
      int drivers;
      ctl = {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt};
      drivers = int'(ep) + int'(ce) + int'(ei) + int'(ea) + int'(eu);
      checks++;
      if (t !== et || ctl !== ec) begin
         errors++;
         $display("FAIL %s: t=%b ctl=%b, expected t=%b ctl=%b", name, t, ctl, et, ec);
      end
      checks++;
      if (drivers > 1) begin
         errors++;
         $display("FAIL %s bus_excl: %0d drivers active, expected at most 1", name, drivers);
      end
   endtask

   // Fetch T1..T3 for an instruction starting at T1
   task automatic add_fetch(input logic [3:0] o);
      add(0, 1, o, S1, EP | LM);
      add(0, 1, o, S2, CP);
      add(0, 1, o, S3, CE | LI);
   endtask

   initial begin
      clr = 1'b1; habilita = 1'b0; opcode = 4'h0;

      add(1, 0, 4'h0, S1, EP | LM);
      // LDA
      add_fetch(4'h0);
      add(0, 1, 4'h0, S4, EI | LM);
      add(0, 1, 4'h0, S5, CE | LA);
`ifndef SAP1_SKIP_NOP_EN
      add(0, 1, 4'h0, S6, N_);
`endif
      // ADD with a 3-cycle stall in T5
      add_fetch(4'h1);
      add(0, 1, 4'h1, S4, EI | LM);
      add(0, 0, 4'h1, S5, CE | LB);
      add(0, 0, 4'h1, S5, CE | LB);
      add(0, 0, 4'h1, S5, CE | LB);
      add(0, 1, 4'h1, S5, CE | LB);
      add(0, 1, 4'h1, S6, EU | LA);
      // SUB
      add_fetch(4'h2);
      add(0, 1, 4'h2, S4, EI | LM);
      add(0, 1, 4'h2, S5, CE | LB);
      add(0, 1, 4'h2, S6, EU | LA | SU);
      // OUT
      add_fetch(4'he);
      add(0, 1, 4'he, S4, EA | LO);
`ifndef SAP1_SKIP_NOP_EN
      add(0, 1, 4'he, S5, N_);
      add(0, 1, 4'he, S6, N_);
`endif
      // undefined opcode acts as NOP
      add_fetch(4'h5);
      add(0, 1, 4'h5, S4, N_);
`ifndef SAP1_SKIP_NOP_EN
      add(0, 1, 4'h5, S5, N_);
      add(0, 1, 4'h5, S6, N_);
`endif
      // opcode change in T4 is followed combinationally
      add_fetch(4'h0);
      add(0, 0, 4'h0, S4, EI | LM);
      add(0, 0, 4'he, S4, EA | LO);
      add(0, 0, 4'h7, S4, N_);
      add(1, 0, 4'h0, S1, EP | LM);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         clr = vecs[i].clr; habilita = vecs[i].hab; opcode = vecs[i].op;
         #1;
         check($sformatf("vec%0d", i), vecs[i].t, vecs[i].ctl);
      end

      // async clear in the middle of T3, well away from any clk edge
      @(negedge clk); clr = 1'b0; habilita = 1'b1; opcode = 4'h1;
      @(negedge clk); @(negedge clk); #1;
      check("pre_async_T3", S3, CE | LI);
      #1 clr = 1'b1; #1;
      check("async_clr", S1, EP | LM);
      @(negedge clk); clr = 1'b0; #1;
      check("after_clr_T1", S1, EP | LM);

      // HLT: ring parks in T4 with everything off until clr
      opcode = 4'hf;
      @(negedge clk); @(negedge clk); @(negedge clk); #1;
      check("hlt_T4", S4, N_);
      for (int i = 0; i < 21; i++) begin
         @(negedge clk); #1;
         check($sformatf("halted%0d", i), S4, HL);
      end
      #1 clr = 1'b1; #1;
      check("hlt_clr", S1, EP | LM);
      @(negedge clk); clr = 1'b0; opcode = 4'h0; #1;
      check("hlt_restart_T1", S1, EP | LM);
      @(negedge clk); #1;
      check("hlt_restart_T2", S2, CP);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
